serial_stack_loader: RTL and testbench
======================================

Name: serial_stack_loader

Overview:
- Upstream feeder for the 8-deep byte stack.
- Assembles a serial bit stream into bytes, presents each completed byte on the stack's din/push pins, and holds one pending byte while the stack reports full.
- Counts delivered bytes and flags dropped bytes (sticky).

Parameters:
- WIDTH, 8, data width; must equal the stack data width.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
- clk  in  1  single clock, all logic on rising edge
- clr  in  1  synchronous, active-high reset
- sin  in  1  serial data bit
- sin_valid  in  1  sin is sampled on this edge when high
- sync  in  1  discard the partial byte and restart the bit count
- full_in  in  1  stack full flag
- dout  out  WIDTH  byte to stack din
- push  out  1  push strobe to stack
- busy  out  1  partial byte in progress or byte pending
- byte_cnt  out  8  bytes accepted by stack, wraps 255->0
- overflow  out  1  sticky: a completed byte was dropped

Behaviour:
- Interface: one clock `clk`; reset `clr` is synchronous and active-high.
- Reset (clr=1 at edge) clears everything; clr wins over all other inputs, mid-byte included:
  - dout=0, push=0, busy=0, byte_cnt=0, overflow=0.
  - bit counter=0, shift register=0, pend=0.
- Shifter, counter range 0..WIDTH-1:
  - on sin_valid, shift sin in per MSB_FIRST and increment the counter.
  - The WIDTH-th bit completes a byte: counter returns to 0.
  - sync=1 clears the counter and shift register; any sin_valid in the same cycle is discarded.
- Output stage, one-entry hold register out_reg plus pend flag:
  - dout = out_reg, registered.
  - push = pend & ~full_in, combinational.
  - At each edge where push=1: pend clears and byte_cnt increments, mod 256.
- Latency:
  - Byte completes at edge N; out_reg loads and pend=1 at edge N.
  - push is high during cycle N+1 if full_in=0; the stack captures at edge N+1.
  - Back-to-back bytes at full sin_valid rate never stall.
- Completion while a byte is still pending:
  - If pend=1 and push=1 at that edge: the new byte loads out_reg, pend stays 1, no loss.
  - If pend=1 and full_in=1: the new byte is dropped, out_reg is kept, overflow<=1.
- full_in semantics:
  - The stack raises full only after an attempted push into a full stack.
  - The attempted byte is lost downstream and is not retried here; this block only stops further pushes while full_in=1.
- Stall: while full_in=1, pend holds indefinitely and push stays 0.
- busy = (bit counter != 0) | pend.
- overflow clears only on clr.

Optional Feature:
- Macro: SERIAL_STACK_LOADER_PARITY_EN.
- Defined:
  - One extra bit follows each byte: even parity over data plus parity.
  - Counter range becomes 0..WIDTH.
  - Bad parity: byte discarded (no pend, no push), and output parity_err pulses high for exactly 1 cycle after the parity bit's edge.
  - Good parity: behaves as the base block, one sample later.
- Undefined: no parity bit, no parity_err port.

Decomposition:
- Package stack_pkg:
  - STACK_WIDTH=8, STACK_DEPTH=8.
  - Shift-state enum {S_IDLE, S_SHIFT}.
  - Parity-phase constant for PARITY_EN.
- One natural sub-module: serial_shifter, holding the bit counter, shift register and sync, and emitting byte_done + byte.
- Top keeps the hold register, push logic and counters.

Test Plan:
- Reset, MSB_FIRST=1: send 1,0,1,0,0,1,0,1 with sin_valid every cycle -> dout=8'hA5 and push=1 for exactly one cycle, the cycle after the 8th sample; byte_cnt=1; busy=0 afterwards.
- full_in=1 held from before completion of 8'h3C -> push=0 and dout=8'h3C held; drop full_in after 5 cycles -> push for 1 cycle, byte_cnt+1.
- full_in=1, pending 8'h11, second byte 8'h22 completes -> overflow=1, dout stays 8'h11; release full_in -> 8'h11 pushed, 8'h22 never appears.
- 4 bits sent, then sync=1 together with sin_valid, then 8 bits of 8'hF0 -> dout=8'hF0; partial bits and the sync-cycle bit absent.
- clr asserted after 5 of 8 bits and with pend=1 -> next cycle all outputs 0; the following full byte 8'h5A arrives intact.
- PARITY_EN: byte 8'h07 (three ones) with parity bit 1 -> pushed; same byte with parity bit 0 -> no push, parity_err single pulse, byte_cnt unchanged.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants and types for the serial loader feeding the byte stack.
// Holds the stack geometry, the shifter state enum and the parity phase count.
package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 8;

  // Bit-counter value at which the parity bit is sampled.
  localparam int PARITY_PHASE = STACK_WIDTH;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/serial_shifter.sv
// Serial-to-parallel shifter: bit counter, shift register and sync restart.
// Ports: clk, clr, sin, sin_valid, sync in; o_done, o_byte, o_active out
// (plus o_parity_err when SERIAL_STACK_LOADER_PARITY_EN is defined).
module serial_shifter
  import stack_pkg::*;
#(
  parameter int WIDTH     = STACK_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic             o_done,
  output logic [WIDTH-1:0] o_byte,
  output logic             o_active
`ifdef SERIAL_STACK_LOADER_PARITY_EN
  ,
  output logic             o_parity_err
`endif
);

`ifdef SERIAL_STACK_LOADER_PARITY_EN
  localparam int LAST = PARITY_PHASE;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam int CW = $clog2(LAST + 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_nx;
  logic             w_last;
  shift_state_e     w_state;

  assign w_state  = (r_cnt == '0) ? S_IDLE : S_SHIFT;
  assign o_active = (w_state == S_SHIFT);

  assign w_last  = sin_valid & ~sync & (r_cnt == CW'(LAST));
  assign w_sh_nx = MSB_FIRST ? {r_sh[WIDTH-2:0], sin}
                             : {sin, r_sh[WIDTH-1:1]};

`ifdef SERIAL_STACK_LOADER_PARITY_EN
  logic r_perr;
  logic w_odd;

  // Even parity: data plus parity bit must hold an even count of ones.
  assign w_odd        = ^{r_sh, sin};
  assign o_done       = w_last & ~w_odd;
  assign o_byte       = r_sh;
  assign o_parity_err = r_perr;

  always_ff @(posedge clk) begin
    if (clr) r_perr <= 1'b0;
    else     r_perr <= w_last & w_odd;
  end
`else
  assign o_done = w_last;
  assign o_byte = w_sh_nx;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (sync) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (sin_valid) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
`ifdef SERIAL_STACK_LOADER_PARITY_EN
      // The parity bit is checked, never shifted into the data.
      if (r_cnt != CW'(PARITY_PHASE)) r_sh <= w_sh_nx;
`else
      r_sh <= w_sh_nx;
`endif
    end
  end

endmodule

// File: rtl/serial_stack_loader.sv
// Serial loader for the byte stack: one-entry hold register, push, counters.
// Ports: clk, clr, sin, sin_valid, sync, full_in in; dout, push, busy,
// byte_cnt, overflow out. SERIAL_STACK_LOADER_PARITY_EN adds parity_err.
module serial_stack_loader
  import stack_pkg::*;
#(
  parameter int WIDTH     = STACK_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  input  logic             full_in,
  output logic [WIDTH-1:0] dout,
  output logic             push,
  output logic             busy,
  output logic [7:0]       byte_cnt,
  output logic             overflow
`ifdef SERIAL_STACK_LOADER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  logic             w_done;
  logic [WIDTH-1:0] w_byte;
  logic             w_active;
  logic             w_push;

  logic [WIDTH-1:0] r_out;
  logic             r_pend;
  logic [7:0]       r_cnt;
  logic             r_ovf;

  serial_shifter #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk         (clk),
    .clr         (clr),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .sync        (sync),
    .o_done      (w_done),
    .o_byte      (w_byte),
    .o_active    (w_active)
`ifdef SERIAL_STACK_LOADER_PARITY_EN
    ,
    .o_parity_err(parity_err)
`endif
  );

  assign w_push   = r_pend & ~full_in;
  assign push     = w_push;
  assign dout     = r_out;
  assign busy     = w_active | r_pend;
  assign byte_cnt = r_cnt;
  assign overflow = r_ovf;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_out  <= '0;
      r_pend <= 1'b0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_cnt <= r_cnt + 8'd1;
      // A slot frees up when empty or being pushed this edge.
      if (w_done && (!r_pend || w_push)) begin
        r_out  <= w_byte;
        r_pend <= 1'b1;
      end else begin
        if (w_done) r_ovf <= 1'b1;
        if (w_push) r_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_stack_loader.sv
// Self-checking bench for serial_stack_loader against a queue-based model.
// Directed scenarios followed by randomized serial traffic.
module tb_serial_stack_loader;

  logic       clk = 1'b0;
  logic       clr, sin, sin_valid, sync, full_in;
  logic [7:0] dout;
  logic       push, busy, overflow;
  logic [7:0] byte_cnt;
`ifdef SERIAL_STACK_LOADER_PARITY_EN
  logic       parity_err;
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_bits[$];
  bit         m_pend;
  bit   [7:0] m_out;
  bit   [7:0] m_cnt;
  bit         m_ovf;
  bit         m_perr;

  always #5 clk = ~clk;

  serial_stack_loader #(
    .WIDTH    (8),
    .MSB_FIRST(1'b1)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sync      (sync),
    .full_in   (full_in),
    .dout      (dout),
    .push      (push),
    .busy      (busy),
    .byte_cnt  (byte_cnt),
    .overflow  (overflow)
`ifdef SERIAL_STACK_LOADER_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pend = 0;
    m_out  = 0;
    m_cnt  = 0;
    m_ovf  = 0;
    m_perr = 0;
  endtask

  // Model: collect bits in a list; a full list becomes a byte.
  task automatic model_step(input bit s, v, sy, f, c);
    bit       pu, done, good;
    bit [7:0] b;
    int       ones;
    if (c) begin
      model_reset();
      return;
    end
    pu   = m_pend && !f;
    done = 0;
    m_perr = 0;
    if (pu) begin
      m_cnt  = m_cnt + 1;
      m_pend = 0;
    end
    if (sy) m_bits.delete();
    else if (v) begin
      m_bits.push_back(s);
      if (m_bits.size() == NBITS) begin
        b = 0;
        ones = 0;
        for (int i = 0; i < 8; i++)
          if (m_bits[i] != 0) b[7-i] = 1'b1;
        for (int i = 0; i < NBITS; i++) ones += m_bits[i];
        good = (ones % 2 == 0) || (NBITS == 8);
        m_perr = !good;
        done = good;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_pend) begin
        m_out  = b;
        m_pend = 1;
      end else m_ovf = 1;
    end
  endtask

  task automatic check_all();
    chk("dout", dout, m_out);
    chk("push", {7'd0, push}, {7'd0, m_pend & ~full_in});
    chk("busy", {7'd0, busy},
        {7'd0, (m_bits.size() != 0) || m_pend});
    chk("byte_cnt", byte_cnt, m_cnt);
    chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
`ifdef SERIAL_STACK_LOADER_PARITY_EN
    chk("parity_err", {7'd0, parity_err}, {7'd0, m_perr});
`endif
  endtask

  task automatic cyc(input bit s, v, sy, f, c);
    sin = s;
    sin_valid = v;
    sync = sy;
    full_in = f;
    clr = c;
    #1;
    check_all();
    @(posedge clk);
    model_step(s, v, sy, f, c);
    #1;
  endtask

  task automatic send(input bit [7:0] b, input bit f, input bit bad);
    for (int i = 7; i >= 0; i--) cyc(b[i], 1, 0, f, 0);
`ifdef SERIAL_STACK_LOADER_PARITY_EN
    cyc((^b) ^ bad, 1, 0, f, 0);
`endif
  endtask

  task automatic idle(input bit f, input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, f, 0);
  endtask

  initial begin
    bit f;
    sin = 0; sin_valid = 0; sync = 0; full_in = 0; clr = 1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    clr = 0;
    chk("rst_dout", dout, 8'h00);
    chk("rst_cnt", byte_cnt, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    idle(0, 2);

    // A5 MSB first, single push
    send(8'hA5, 0, 0);
    chk("a5_dout", dout, 8'hA5);
    chk("a5_push", {7'd0, push}, 8'h01);
    idle(0, 1);
    chk("a5_push_off", {7'd0, push}, 8'h00);
    chk("a5_cnt", byte_cnt, 8'h01);
    chk("a5_busy", {7'd0, busy}, 8'h00);

    // Stall on full
    full_in = 1;
    send(8'h3C, 1, 0);
    idle(1, 5);
    chk("3c_hold", dout, 8'h3C);
    chk("3c_nopush", {7'd0, push}, 8'h00);
    idle(0, 2);
    chk("3c_cnt", byte_cnt, 8'h02);

    // Drop while pending
    send(8'h11, 1, 0);
    send(8'h22, 1, 0);
    chk("ovf_set", {7'd0, overflow}, 8'h01);
    chk("ovf_dout", dout, 8'h11);
    idle(0, 3);
    chk("ovf_cnt", byte_cnt, 8'h03);
    chk("ovf_dout2", dout, 8'h11);

    // Sync discards partial and same-cycle bit
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    send(8'hF0, 0, 0);
    chk("sync_dout", dout, 8'hF0);
    idle(0, 2);
    chk("sync_cnt", byte_cnt, 8'h04);

    // clr mid-byte with a pending byte
    send(8'h77, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 1);
    chk("clr_dout", dout, 8'h00);
    chk("clr_busy", {7'd0, busy}, 8'h00);
    chk("clr_cnt", byte_cnt, 8'h00);
    chk("clr_ovf", {7'd0, overflow}, 8'h00);
    send(8'h5A, 0, 0);
    idle(0, 1);
    chk("5a_dout", dout, 8'h5A);
    chk("5a_cnt", byte_cnt, 8'h01);

`ifdef SERIAL_STACK_LOADER_PARITY_EN
    send(8'h07, 0, 0);
    idle(0, 2);
    chk("par_good_cnt", byte_cnt, 8'h02);
    send(8'h07, 0, 1);
    chk("par_err", {7'd0, parity_err}, 8'h01);
    idle(0, 1);
    chk("par_err_off", {7'd0, parity_err}, 8'h00);
    chk("par_bad_cnt", byte_cnt, 8'h02);
`endif

    // Randomized traffic
    f = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) f = ~f;
      cyc($urandom_range(0, 1), $urandom_range(0, 3) != 0,
          $urandom_range(0, 40) == 0, f,
          $urandom_range(0, 300) == 0);
    end
    idle(0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
